// File: rtl/xgmii_lpbk_channel.sv
// ---------------------------------------------------------------------------
// xgmii_lpbk_channel
//   XGMII TX->RX channel for the MAC top/bench. The RX stream is taken either
//   from the MAC's own TX (loopback) or from an external source. Mode changes
//   are deferred until the active source presents an IDLE word, so a frame is
//   never cut short or merged with another. The chosen stream goes through a
//   fixed DELAY-cycle pipeline. One armed error injection turns a single data
//   byte into /E/. Saturating counters track /S/ words on the output and the
//   injections that have been applied.
//
// Ports
//   clk_156m25    in   clock; all logic runs on its rising edge
//   reset_156m25  in   synchronous, active-high reset
//   xgmii_txd/txc in   MAC TX word (loopback source)
//   ext_rxd/rxc   in   external RX word
//   lpbk_en       in   requested mode (1 = loopback, 0 = external)
//   err_inj_req   in   pulse that arms one injection on lane err_lane
//   err_lane      in   lane to corrupt, latched when the request arms
//   xgmii_rxd/rxc out  delayed RX word to the MAC
//   lpbk_active   out  mode currently in effect
//   err_inj_done  out  pulse one cycle after an injection is applied
//   sop_count     out  saturating count of output words containing /S/
//   err_count     out  saturating count of injections applied
//
// Mode FSM
//   state     | meaning
//   ST_EXT    | external source selected
//   ST_PEND_L | loopback requested, waiting for external IDLE
//   ST_LPBK   | loopback source selected
//   ST_PEND_E | external requested, waiting for TX IDLE
// ---------------------------------------------------------------------------
module xgmii_lpbk_channel #(
  parameter int NUM_LANES    = 8,
  parameter int DELAY        = 4,
  parameter int CNT_W        = 16,
  parameter bit LPBK_DEFAULT = 1'b1
) (
  input  logic                         clk_156m25,
  input  logic                         reset_156m25,
  input  logic [8*NUM_LANES-1:0]       xgmii_txd,
  input  logic [NUM_LANES-1:0]         xgmii_txc,
  input  logic [8*NUM_LANES-1:0]       ext_rxd,
  input  logic [NUM_LANES-1:0]         ext_rxc,
  input  logic                         lpbk_en,
  input  logic                         err_inj_req,
  input  logic [$clog2(NUM_LANES)-1:0] err_lane,
  output logic [8*NUM_LANES-1:0]       xgmii_rxd,
  output logic [NUM_LANES-1:0]         xgmii_rxc,
  output logic                         lpbk_active,
  output logic                         err_inj_done,
  output logic [CNT_W-1:0]             sop_count,
  output logic [CNT_W-1:0]             err_count
);

  localparam int DW = 8 * NUM_LANES;
  localparam int LW = $clog2(NUM_LANES);
  localparam logic [DW-1:0]        IDLE_D = {NUM_LANES{8'h07}};
  localparam logic [NUM_LANES-1:0] IDLE_C = '1;

  typedef enum logic [1:0] {
    ST_EXT    = 2'd0,
    ST_PEND_L = 2'd1,
    ST_LPBK   = 2'd2,
    ST_PEND_E = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]        src_d;
  logic [NUM_LANES-1:0] src_c;
  logic                 src_idle;
  logic                 src_is_tx;

  logic                 armed;
  logic [LW-1:0]        lane_q;
  logic                 inj_hit;
  logic [DW-1:0]        inj_d;
  logic [NUM_LANES-1:0] inj_c;

  logic [DW-1:0]        pipe_d [DELAY];
  logic [NUM_LANES-1:0] pipe_c [DELAY];
  logic                 out_sop;

  // The pending states keep the old source until the switch point.
  assign src_is_tx   = (state == ST_LPBK) || (state == ST_PEND_E);
  assign lpbk_active = src_is_tx;
  assign src_d       = src_is_tx ? xgmii_txd : ext_rxd;
  assign src_c       = src_is_tx ? xgmii_txc : ext_rxc;
  assign src_idle    = (src_c == IDLE_C) && (src_d == IDLE_D);

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) state <= LPBK_DEFAULT ? ST_LPBK : ST_EXT;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EXT:    if (lpbk_en)       state_nxt = ST_PEND_L;
      ST_PEND_L: if (!lpbk_en)      state_nxt = ST_EXT;
                 else if (src_idle) state_nxt = ST_LPBK;
      ST_LPBK:   if (!lpbk_en)      state_nxt = ST_PEND_E;
      ST_PEND_E: if (lpbk_en)       state_nxt = ST_LPBK;
                 else if (src_idle) state_nxt = ST_EXT;
      default:                      state_nxt = ST_EXT;
    endcase
  end

  // Only data lanes are eligible; a control lane is left alone.
  assign inj_hit = armed && !src_c[lane_q];

  always_comb begin
    inj_d = src_d;
    inj_c = src_c;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (inj_hit && (lane_q == LW'(i))) begin
        inj_d[8*i +: 8] = 8'hFE;
        inj_c[i]        = 1'b1;
      end
    end
  end

  // Arming and applying are mutually exclusive, so a request that coincides
  // with an eligible word only takes effect on a later word.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      armed        <= 1'b0;
      lane_q       <= '0;
      err_inj_done <= 1'b0;
    end else begin
      err_inj_done <= inj_hit;
      if (inj_hit) begin
        armed <= 1'b0;
      end else if (err_inj_req && !armed) begin
        armed  <= 1'b1;
        lane_q <= err_lane;
      end
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_d[i] <= IDLE_D;
        pipe_c[i] <= IDLE_C;
      end
    end else begin
      pipe_d[0] <= inj_d;
      pipe_c[0] <= inj_c;
      for (int i = 1; i < DELAY; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_c[i] <= pipe_c[i-1];
      end
    end
  end

  assign xgmii_rxd = pipe_d[DELAY-1];
  assign xgmii_rxc = pipe_c[DELAY-1];

  always_comb begin
    out_sop = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFB)) out_sop = 1'b1;
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      sop_count <= '0;
      err_count <= '0;
    end else begin
      if (out_sop && (sop_count != '1)) sop_count <= sop_count + CNT_W'(1);
      if (inj_hit && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xgmii_lpbk_channel.sv
module tb_xgmii_lpbk_channel;

  localparam int DL = 4;
  localparam logic [63:0] IDLE_D = {8{8'h07}};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] txd, ext_d;
  logic [7:0]  txc, ext_c;
  logic        lpbk_en, req;
  logic [2:0]  lane;

  logic [63:0] rxd, s_rxd;
  logic [7:0]  rxc, s_rxc;
  logic        act, done, s_act, s_done;
  logic [15:0] sop, err;
  logic [3:0]  s_sop, s_err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  xgmii_lpbk_channel #(.NUM_LANES(8), .DELAY(DL), .CNT_W(16), .LPBK_DEFAULT(1'b1)) u_dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .xgmii_txd(txd), .xgmii_txc(txc), .ext_rxd(ext_d), .ext_rxc(ext_c),
    .lpbk_en(lpbk_en), .err_inj_req(req), .err_lane(lane),
    .xgmii_rxd(rxd), .xgmii_rxc(rxc), .lpbk_active(act), .err_inj_done(done),
    .sop_count(sop), .err_count(err)
  );

  xgmii_lpbk_channel #(.NUM_LANES(8), .DELAY(DL), .CNT_W(4), .LPBK_DEFAULT(1'b1)) u_sat (
    .clk_156m25(clk), .reset_156m25(rst),
    .xgmii_txd(txd), .xgmii_txc(txc), .ext_rxd(ext_d), .ext_rxc(ext_c),
    .lpbk_en(lpbk_en), .err_inj_req(req), .err_lane(lane),
    .xgmii_rxd(s_rxd), .xgmii_rxc(s_rxc), .lpbk_active(s_act), .err_inj_done(s_done),
    .sop_count(s_sop), .err_count(s_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: output is a FIFO of words DL deep; mode is "current
  // source" plus a "switch pending" flag.
  logic [63:0] mq_d[$];
  logic [7:0]  mq_c[$];
  bit          m_src_tx, m_pend, m_armed, m_done;
  logic [2:0]  m_lane;
  int unsigned m_sop, m_err;

  function automatic bit has_sop(input logic [63:0] d, input logic [7:0] c);
    for (int i = 0; i < 8; i++) if (c[i] && d[8*i +: 8] == 8'hFB) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq_d.delete(); mq_c.delete();
    for (int i = 0; i < DL; i++) begin mq_d.push_back(IDLE_D); mq_c.push_back(8'hFF); end
    m_src_tx = 1'b1; m_pend = 1'b0; m_armed = 1'b0; m_done = 1'b0;
    m_lane = '0; m_sop = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [63:0] d;
    logic [7:0]  c;
    bit          idle;
    if (rst) begin model_reset(); return; end
    d = m_src_tx ? txd : ext_d;
    c = m_src_tx ? txc : ext_c;
    idle = (c == 8'hFF) && (d == IDLE_D);
    if (has_sop(mq_d[0], mq_c[0])) m_sop++;
    m_done = 1'b0;
    if (m_armed && !c[m_lane]) begin
      d[m_lane*8 +: 8] = 8'hFE;
      c[m_lane] = 1'b1;
      m_done = 1'b1; m_err++; m_armed = 1'b0;
    end else if (req && !m_armed) begin
      m_armed = 1'b1; m_lane = lane;
    end
    if (!m_pend) begin
      if (lpbk_en != m_src_tx) m_pend = 1'b1;
    end else if (lpbk_en == m_src_tx) begin
      m_pend = 1'b0;
    end else if (idle) begin
      m_src_tx = !m_src_tx; m_pend = 1'b0;
    end
    mq_d.push_back(d); mq_c.push_back(c);
    void'(mq_d.pop_front()); void'(mq_c.pop_front());
  endtask

  task automatic check_outputs();
    chk("rxd", rxd, mq_d[0]);
    chk("rxc", rxc, mq_c[0]);
    chk("lpbk_active", act, m_src_tx);
    chk("err_inj_done", done, m_done);
    chk("sop_count", sop, m_sop);
    chk("err_count", err, m_err);
    chk("sat_rxd", {s_rxc, s_rxd}, {mq_c[0], mq_d[0]});
    chk("sat_sop", s_sop, (m_sop > 15) ? 15 : m_sop);
    chk("sat_err", s_err, (m_err > 15) ? 15 : m_err);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Frame generators: stream 0 = MAC TX, stream 1 = external.
  int g_pos[2], g_len[2], g_gap[2];
  bit g_hold[2];

  task automatic gen_step(input int s, output logic [63:0] d, output logic [7:0] c);
    if (g_pos[s] == 0) begin
      if (g_gap[s] > 0 || g_hold[s]) begin
        d = IDLE_D; c = 8'hFF;
        if (g_gap[s] > 0) g_gap[s]--;
      end else begin
        d = {$urandom(), $urandom()}; d[7:0] = 8'hFB; c = 8'h01;
        g_pos[s] = 1; g_len[s] = $urandom_range(1, 6);
      end
    end else if (g_pos[s] <= g_len[s]) begin
      d = {$urandom(), $urandom()}; c = 8'h00; g_pos[s]++;
    end else begin
      d = {{7{8'h07}}, 8'hFD}; c = 8'hFF;
      g_pos[s] = 0; g_gap[s] = $urandom_range(1, 5);
    end
  endtask

  task automatic drive_gen();
    gen_step(0, txd, txc);
    gen_step(1, ext_d, ext_c);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin g_pos[s] = 0; g_len[s] = 1; g_gap[s] = 3; g_hold[s] = 0; end
    rst = 1'b1; lpbk_en = 1'b1; req = 1'b0; lane = '0;
    txd = IDLE_D; txc = 8'hFF; ext_d = IDLE_D; ext_c = 8'hFF;
    model_reset();
    repeat (3) tick();
    chk("reset_rxd", rxd, 64'h0707070707070707);
    chk("reset_rxc", rxc, 8'hFF);
    chk("reset_mode", act, 1'b1);
    chk("reset_cnt", {sop, err}, 32'h0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      drive_gen();
      req  = ($urandom_range(0, 19) == 0);
      lane = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) lpbk_en = !lpbk_en;
      rst = (cyc == 1000);
      tick();
      if (cyc == 1000) begin
        chk("midrst_rxd", {rxc, rxd}, {8'hFF, IDLE_D});
        chk("midrst_cnt", {sop, err, done}, 33'h0);
        chk("midrst_mode", act, 1'b1);
      end
    end
    rst = 1'b0; req = 1'b0;

    // Idle-only traffic: a request must stay armed until a frame arrives.
    g_hold[0] = 1; g_hold[1] = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      drive_gen();
      req  = (cyc == 30);
      lane = 3'd3;
      tick();
    end
    req = 1'b0;
    g_hold[0] = 0; g_hold[1] = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      drive_gen();
      tick();
    end

    chk("sat_hold", s_sop, 4'd15);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
